dest_reader: RTL and testbench

- Consumer-side drain engine for the D0/D1 destination FIFOs at the egress of the QoS interconnect; the interconnect's writer side is Main_wr/Main_data_in.
- Arbitrates round-robin between the two destination FIFOs and issues D0_rd/D1_rd, honouring each FIFO's empty flag.
- Absorbs the one-cycle FIFO read latency and presents a single registered output stream tagged with its source.
- Keeps per-destination word counters and flags words whose destination bit disagrees with the FIFO they came from.

---
 rtl/dest_reader_if.sv | 36 +++
 rtl/dest_reader.sv | 125 ++++++++++++
 tb/tb_dest_reader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dest_reader_if.sv
// Destination-FIFO drain bus between the interconnect egress FIFOs and
// the dest_reader, including its capture stream and status outputs.
interface dest_reader_if #(
  parameter int unsigned BW    = 6,
  parameter int unsigned CNT_W = 8
);
  logic             init;
  logic             enable;
  logic             D0_empty;
  logic             D1_empty;
  logic [BW-1:0]    D0_data_out;
  logic [BW-1:0]    D1_data_out;
  logic             D0_rd;
  logic             D1_rd;
  logic [BW-1:0]    data_out;
  logic             valid_out;
  logic             src_out;
  logic [CNT_W-1:0] cnt_D0;
  logic [CNT_W-1:0] cnt_D1;
  logic             mismatch_err;
  logic             idle;

  // Drain engine side: pops the FIFOs and drives the captured stream.
  modport master (
    input  init, enable, D0_empty, D1_empty, D0_data_out, D1_data_out,
    output D0_rd, D1_rd, data_out, valid_out, src_out,
           cnt_D0, cnt_D1, mismatch_err, idle
  );

  // FIFO / consumer side.
  modport slave (
    output init, enable, D0_empty, D1_empty, D0_data_out, D1_data_out,
    input  D0_rd, D1_rd, data_out, valid_out, src_out,
           cnt_D0, cnt_D1, mismatch_err, idle
  );
endinterface

// File: rtl/dest_reader.sv
// Round-robin drain engine for the D0/D1 destination FIFOs. Issues pops,
// absorbs the one-cycle FIFO read latency, and emits a registered, source
// tagged word stream with per-destination counters and a sticky flag for
// words whose destination bit disagrees with the FIFO they came from.
module dest_reader #(
  parameter int unsigned BW    = 6,
  parameter int unsigned CNT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  dest_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  state_t           state_d;
  logic             last_q;
  logic             pend_q;
  logic             psrc_q;
  logic [BW-1:0]    data_q;
  logic             valid_q;
  logic             src_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;
  logic             err_q;
  logic             idle_q;

  logic             rd0_c;
  logic             rd1_c;
  logic             grant_c;
  logic [BW-1:0]    pdata_c;

  // Round-robin grant: favour the FIFO not served last; never pop an empty one.
  always_comb begin
    rd0_c = 1'b0;
    rd1_c = 1'b0;
    if (!reset && bus.enable && !bus.init) begin
      if (!bus.D0_empty && !bus.D1_empty) begin
        rd0_c = last_q;
        rd1_c = ~last_q;
      end else begin
        rd0_c = ~bus.D0_empty;
        rd1_c = ~bus.D1_empty;
      end
    end
    grant_c = rd0_c | rd1_c;
  end

  // Next-state for the activity tracker; DRAIN covers the last capture after the final pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant_c ? ACTIVE : IDLE;
      ACTIVE:  state_d = grant_c ? ACTIVE : (pend_q ? DRAIN : IDLE);
      DRAIN:   state_d = grant_c ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data of the FIFO popped on the previous cycle.
  assign pdata_c = psrc_q ? bus.D1_data_out : bus.D0_data_out;

  // Pipeline, capture, counters, error flag, arbiter pointer and FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      pend_q  <= 1'b0;
      psrc_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      pend_q  <= grant_c;
      valid_q <= pend_q;
      if (grant_c) begin
        last_q <= rd1_c;
        psrc_q <= rd1_c;
      end
      if (pend_q) begin
        data_q <= pdata_c;
        src_q  <= psrc_q;
        if (pdata_c[BW-2] != psrc_q) begin
          err_q <= 1'b1;
        end
        if (psrc_q) begin
          cnt1_q <= (cnt1_q == CNT_MAX) ? cnt1_q : cnt1_q + CNT_W'(1);
        end else begin
          cnt0_q <= (cnt0_q == CNT_MAX) ? cnt0_q : cnt0_q + CNT_W'(1);
        end
      end
      // init overrides any same-cycle increment or error set
      if (bus.init) begin
        cnt0_q <= '0;
        cnt1_q <= '0;
        err_q  <= 1'b0;
        last_q <= 1'b1;
      end
      state_q <= state_d;
      idle_q  <= (state_d == IDLE) && bus.D0_empty && bus.D1_empty;
    end
  end

  assign bus.D0_rd        = rd0_c;
  assign bus.D1_rd        = rd1_c;
  assign bus.data_out     = data_q;
  assign bus.valid_out    = valid_q;
  assign bus.src_out      = src_q;
  assign bus.cnt_D0       = cnt0_q;
  assign bus.cnt_D1       = cnt1_q;
  assign bus.mismatch_err = err_q;
  assign bus.idle         = idle_q;

endmodule

// File: tb/tb_dest_reader.sv
// Bench for dest_reader: queue-based FIFO emulation, a transaction-level
// reference model checked every cycle, and directed literal checks.
module tb_dest_reader;

  localparam int unsigned BW = 6;

  logic clk;
  logic reset;

  dest_reader_if #(.BW(BW), .CNT_W(8)) bus  ();
  dest_reader_if #(.BW(BW), .CNT_W(2)) bus2 ();

  dest_reader #(.BW(BW), .CNT_W(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dest_reader #(.BW(BW), .CNT_W(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // FIFO emulation: pop on the edge after a sampled rd.
  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  bit rd0_s;
  bit rd1_s;

  always @(negedge clk) begin
    rd0_s = bus.D0_rd;
    rd1_s = bus.D1_rd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rd0_s && q0.size() > 0) bus.D0_data_out = q0.pop_front();
    if (rd1_s && q1.size() > 0) bus.D1_data_out = q1.pop_front();
    bus.D0_empty = (q0.size() == 0);
    bus.D1_empty = (q1.size() == 0);
  endtask

  task automatic push0(input logic [BW-1:0] w);
    q0.push_back(w);
    bus.D0_empty = 1'b0;
  endtask

  task automatic push1(input logic [BW-1:0] w);
    q1.push_back(w);
    bus.D1_empty = 1'b0;
  endtask

  // Reference model: expected register contents after the next edge.
  int            m_last;
  bit            m_fly;
  int            m_fsrc;
  logic [BW-1:0] e_data;
  bit            e_valid;
  bit            e_src;
  bit            e_err;
  bit            e_idle;
  int            e_cnt0;
  int            e_cnt1;

  function automatic int pick();
    if (reset || !bus.enable || bus.init) return -1;
    if (!bus.D0_empty && !bus.D1_empty) return (m_last == 1) ? 0 : 1;
    if (!bus.D0_empty) return 0;
    if (!bus.D1_empty) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    int            g;
    logic [BW-1:0] w;
    if (reset) begin
      m_last = 1; m_fly = 0; m_fsrc = 0;
      e_data = '0; e_valid = 0; e_src = 0; e_err = 0; e_idle = 1;
      e_cnt0 = 0; e_cnt1 = 0;
    end
    g = pick();
    chk("D0_rd",        32'(bus.D0_rd),        32'(g == 0));
    chk("D1_rd",        32'(bus.D1_rd),        32'(g == 1));
    chk("data_out",     32'(bus.data_out),     32'(e_data));
    chk("valid_out",    32'(bus.valid_out),    32'(e_valid));
    chk("src_out",      32'(bus.src_out),      32'(e_src));
    chk("cnt_D0",       32'(bus.cnt_D0),       32'(e_cnt0));
    chk("cnt_D1",       32'(bus.cnt_D1),       32'(e_cnt1));
    chk("mismatch_err", 32'(bus.mismatch_err), 32'(e_err));
    chk("idle",         32'(bus.idle),         32'(e_idle));
    if (!reset) begin
      if (m_fly) begin
        w = (m_fsrc == 1) ? bus.D1_data_out : bus.D0_data_out;
        e_data  = w;
        e_src   = (m_fsrc == 1);
        e_valid = 1;
        if (m_fsrc == 1) e_cnt1 = (e_cnt1 < 255) ? e_cnt1 + 1 : 255;
        else             e_cnt0 = (e_cnt0 < 255) ? e_cnt0 + 1 : 255;
        if (w[BW-2] != (m_fsrc == 1)) e_err = 1;
      end else begin
        e_valid = 0;
      end
      if (bus.init) begin
        e_cnt0 = 0; e_cnt1 = 0; e_err = 0; m_last = 1;
      end
      e_idle = (g < 0) && !m_fly && bus.D0_empty && bus.D1_empty;
      m_fly  = (g >= 0);
      if (g >= 0) begin
        m_fsrc = g;
        m_last = g;
      end
    end
  end

  logic [9:0] rd0_v;
  logic [9:0] rd1_v;
  logic [9:0] val_v;
  int         nv;

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1;
    bus.init = 0; bus.enable = 0; bus.D0_empty = 1; bus.D1_empty = 1;
    bus.D0_data_out = '0; bus.D1_data_out = '0;
    bus2.init = 0; bus2.enable = 0; bus2.D0_empty = 1; bus2.D1_empty = 1;
    bus2.D0_data_out = 6'h01; bus2.D1_data_out = '0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_idle",  32'(bus.idle),      32'd1);
    chk("rst_cnt0",  32'(bus.cnt_D0),    32'd0);

    // single D0 word: 2-edge rd-to-valid latency
    tick();
    bus.enable = 1;
    push0(6'b000101);
    @(negedge clk);
    chk("t1_rd0", 32'(bus.D0_rd), 32'd1);
    tick(); tick();
    @(negedge clk);
    chk("t1_valid", 32'(bus.valid_out), 32'd1);
    chk("t1_data",  32'(bus.data_out),  32'h05);
    chk("t1_src",   32'(bus.src_out),   32'd0);
    chk("t1_cnt0",  32'(bus.cnt_D0),    32'd1);

    // both FIFOs busy: strict alternation from D0, back-to-back valid
    tick();
    bus.init = 1;
    tick();
    bus.init = 0;
    push0(6'h01); push0(6'h02); push0(6'h03);
    push1(6'h11); push1(6'h12); push1(6'h13);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rd0_v[i] = bus.D0_rd;
      rd1_v[i] = bus.D1_rd;
      val_v[i] = bus.valid_out;
      tick();
    end
    chk("t2_rd0_seq", 32'(rd0_v), 32'(10'b0000010101));
    chk("t2_rd1_seq", 32'(rd1_v), 32'(10'b0000101010));
    chk("t2_valid",   32'(val_v), 32'(10'b0011111100));
    @(negedge clk);
    chk("t2_cnt0", 32'(bus.cnt_D0), 32'd3);
    chk("t2_cnt1", 32'(bus.cnt_D1), 32'd3);

    // bad destination bit from D1, then a good word: flag stays set
    tick();
    push1(6'b000011);
    push1(6'h14);
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    chk("t3_err",  32'(bus.mismatch_err), 32'd1);
    chk("t3_cnt1", 32'(bus.cnt_D1),       32'd5);
    tick();
    bus.init = 1;
    tick();
    bus.init = 0;
    @(negedge clk);
    chk("t3_init_err",  32'(bus.mismatch_err), 32'd0);
    chk("t3_init_cnt0", 32'(bus.cnt_D0),       32'd0);
    chk("t3_init_cnt1", 32'(bus.cnt_D1),       32'd0);

    // enable drops after a pop: pending word still delivered
    tick();
    push0(6'h07); push0(6'h08);
    @(negedge clk);
    chk("t4_rd0", 32'(bus.D0_rd), 32'd1);
    tick();
    bus.enable = 0;
    @(negedge clk);
    chk("t4_no_rd", 32'(bus.D0_rd), 32'd0);
    tick();
    @(negedge clk);
    chk("t4_valid", 32'(bus.valid_out), 32'd1);
    chk("t4_data",  32'(bus.data_out),  32'h07);
    tick();
    @(negedge clk);
    chk("t4_idle_busy", 32'(bus.idle), 32'd0);
    tick();
    bus.enable = 1;
    tick(); tick(); tick();
    @(negedge clk);
    chk("t4_idle", 32'(bus.idle),   32'd1);
    chk("t4_cnt0", 32'(bus.cnt_D0), 32'd2);

    // reset lands while a read is in flight
    tick();
    push0(6'h09);
    @(negedge clk);
    chk("t6_rd0", 32'(bus.D0_rd), 32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_data",  32'(bus.data_out),  32'd0);
    chk("t6_valid", 32'(bus.valid_out), 32'd0);
    chk("t6_cnt0",  32'(bus.cnt_D0),    32'd0);
    tick();
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nv += int'(bus.valid_out);
      tick();
    end
    chk("t6_no_valid", 32'(nv), 32'd0);
    chk("t6_cnt0_after", 32'(bus.cnt_D0), 32'd0);

    // 2-bit counter saturates at 3 after five captures
    bus2.D0_empty = 0;
    bus2.enable = 1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nv += int'(bus2.valid_out);
      if (i == 3) chk("t5_cnt_mid", 32'(bus2.cnt_D0), 32'd2);
      tick();
      if (i == 4) bus2.enable = 0;
    end
    chk("t5_captures", 32'(nv),                32'd5);
    chk("t5_cnt_sat",  32'(bus2.cnt_D0),       32'd3);
    chk("t5_err",      32'(bus2.mismatch_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
